// File: rtl/crc_pkg.sv
// crc_pkg: shared types and constants for the CRC CBUS sequencer.
// Holds the channel count, the word-count width, the GRANT timeout and the FSM state type.
package crc_pkg;
    localparam int NCHAN = 8;
    localparam int WC_W  = 11;
    localparam int TMO   = 15;
    typedef logic [2:0]      chan_t;
    typedef logic [WC_W-1:0] wc_t;
    typedef enum logic [2:0] {IDLE, ARB, GRANT, UPDATE, ERR} crc_state_t;
endpackage

// File: rtl/crc_wc_ram.sv
// crc_wc_ram: per-channel word-count and reverse-flag register file.
// Ports: clk_i/rst_ni clock and async active-low reset; load_* writes count+rev;
// dec_i/dec_chan_i decrement one count; rd_chan_i async read of rd_wc_o/rd_rev_o;
// wc_zero_o flags every channel whose count is 0.
module crc_wc_ram
    import crc_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  chan_t            load_chan_i,
    input  wc_t              load_val_i,
    input  logic             load_rev_i,
    input  logic             dec_i,
    input  chan_t            dec_chan_i,
    input  chan_t            rd_chan_i,
    output wc_t              rd_wc_o,
    output logic             rd_rev_o,
    output logic [NCHAN-1:0] wc_zero_o
);
    wc_t              wc_q [NCHAN];
    logic [NCHAN-1:0] rev_q;

    // A load always beats a decrement of the same entry; a zero count is never decremented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCHAN; i++) wc_q[i] <= '0;
            rev_q <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (load_i && load_chan_i == chan_t'(i)) begin
                    wc_q[i]  <= load_val_i;
                    rev_q[i] <= load_rev_i;
                end else if (dec_i && dec_chan_i == chan_t'(i) && wc_q[i] != '0) begin
                    wc_q[i] <= wc_q[i] - wc_t'(1);
                end
            end
        end
    end

    assign rd_wc_o  = wc_q[rd_chan_i];
    assign rd_rev_o = rev_q[rd_chan_i];

    for (genvar g = 0; g < NCHAN; g++) begin : g_zero
        assign wc_zero_o[g] = wc_q[g] == '0;
    end
endmodule

// File: rtl/crc_cbus_seq.sv
// crc_cbus_seq: round-robin CBUS word sequencer feeding the channel control stage.
// Ports: clk1_crc_h/mr_reset_l clock and async active-low reset; cbus_chan_req_h per-channel
// requests; cbus_ready_e_h word acknowledge; wc_load_* word-count load; crc_* slot outputs
// (selected channel, RAM address, ready, last word, error, reverse, RAM write strobe,
// slot-owned flag, per-channel zero-count flags).
module crc_cbus_seq
    import crc_pkg::*;
(
    input  logic             clk1_crc_h,
    input  logic             mr_reset_l,
    input  logic [NCHAN-1:0] cbus_chan_req_h,
    input  logic             cbus_ready_e_h,
    input  logic             wc_load_h,
    input  logic [2:0]       wc_load_chan,
    input  logic [WC_W-1:0]  wc_load_val,
    input  logic             wc_load_rev,
    output logic [2:0]       crc_sel_c_h,
    output logic [2:0]       crc_ram_adr_r_l,
    output logic             crc_ready_in_h,
    output logic             crc_last_word_in_h,
    output logic             crc_err_in_h,
    output logic             crc_reverse_in_h,
    output logic             crc_wr_ram_l,
    output logic             crc_cbus_contr_cyc_l,
    output logic [NCHAN-1:0] crc_wc_zero_h
);
    crc_state_t state_q, state_d;
    chan_t      sel_q, sel_d, adr_q, adr_d, ptr_q, ptr_d, pick;
    logic [3:0] tmo_q, tmo_d;
    wc_t        wc;
    logic       rev;

    crc_wc_ram u_ram (
        .clk_i       (clk1_crc_h),
        .rst_ni      (mr_reset_l),
        .load_i      (wc_load_h),
        .load_chan_i (wc_load_chan),
        .load_val_i  (wc_load_val),
        .load_rev_i  (wc_load_rev),
        .dec_i       (state_q == UPDATE),
        .dec_chan_i  (sel_q),
        .rd_chan_i   (sel_q),
        .rd_wc_o     (wc),
        .rd_rev_o    (rev),
        .wc_zero_o   (crc_wc_zero_h)
    );

    // Scanning from the far end down leaves the nearest requester at or after the pointer.
    always_comb begin
        pick = ptr_q;
        for (int i = NCHAN - 1; i >= 0; i--)
            if (cbus_chan_req_h[ptr_q + chan_t'(i)]) pick = ptr_q + chan_t'(i);
    end

    always_comb begin
        state_d            = state_q;
        sel_d              = sel_q;
        adr_d              = adr_q;
        ptr_d              = ptr_q;
        tmo_d              = tmo_q;
        crc_ready_in_h     = 1'b0;
        crc_last_word_in_h = 1'b0;
        crc_err_in_h       = 1'b0;
        crc_reverse_in_h   = 1'b0;
        case (state_q)
            IDLE: if (|cbus_chan_req_h) state_d = ARB;
            ARB: begin
                tmo_d   = '0;
                state_d = |cbus_chan_req_h ? GRANT : IDLE;
                if (|cbus_chan_req_h) begin
                    sel_d = pick;
                    adr_d = ~pick;
                end
            end
            GRANT: begin
                crc_reverse_in_h = rev;
                if (wc == '0) begin
                    crc_err_in_h = 1'b1;
                    state_d      = ERR;
                end else begin
                    crc_ready_in_h     = 1'b1;
                    crc_last_word_in_h = wc == wc_t'(1);
                    // An acknowledge in the timeout cycle still retires the word.
                    if (cbus_ready_e_h) state_d = UPDATE;
                    else if (tmo_q == 4'(TMO - 1)) begin
                        crc_err_in_h = 1'b1;
                        state_d      = ERR;
                    end else tmo_d = tmo_q + 4'd1;
                end
            end
            UPDATE: begin
                ptr_d   = sel_q + 3'd1;
                state_d = IDLE;
            end
            ERR: begin
                crc_err_in_h = 1'b1;
                ptr_d        = sel_q + 3'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1_crc_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state_q <= IDLE;
            sel_q   <= '0;
            adr_q   <= '1;
            ptr_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign crc_sel_c_h          = sel_q;
    assign crc_ram_adr_r_l      = adr_q;
    assign crc_wr_ram_l         = state_q != UPDATE;
    assign crc_cbus_contr_cyc_l = state_q == IDLE;
endmodule

// File: tb/tb_crc_cbus_seq.sv
// tb_crc_cbus_seq: directed self-checking bench for crc_cbus_seq.
module tb_crc_cbus_seq;
    import crc_pkg::*;

    logic             clk1_crc_h = 1'b0;
    logic             mr_reset_l = 1'b1;
    logic [NCHAN-1:0] cbus_chan_req_h = '0;
    logic             cbus_ready_e_h = 1'b0;
    logic             wc_load_h = 1'b0;
    logic [2:0]       wc_load_chan = '0;
    logic [WC_W-1:0]  wc_load_val = '0;
    logic             wc_load_rev = 1'b0;
    logic [2:0]       crc_sel_c_h, crc_ram_adr_r_l;
    logic             crc_ready_in_h, crc_last_word_in_h, crc_err_in_h, crc_reverse_in_h;
    logic             crc_wr_ram_l, crc_cbus_contr_cyc_l;
    logic [NCHAN-1:0] crc_wc_zero_h;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;

    crc_cbus_seq dut (
        .clk1_crc_h           (clk1_crc_h),
        .mr_reset_l           (mr_reset_l),
        .cbus_chan_req_h      (cbus_chan_req_h),
        .cbus_ready_e_h       (cbus_ready_e_h),
        .wc_load_h            (wc_load_h),
        .wc_load_chan         (wc_load_chan),
        .wc_load_val          (wc_load_val),
        .wc_load_rev          (wc_load_rev),
        .crc_sel_c_h          (crc_sel_c_h),
        .crc_ram_adr_r_l      (crc_ram_adr_r_l),
        .crc_ready_in_h       (crc_ready_in_h),
        .crc_last_word_in_h   (crc_last_word_in_h),
        .crc_err_in_h         (crc_err_in_h),
        .crc_reverse_in_h     (crc_reverse_in_h),
        .crc_wr_ram_l         (crc_wr_ram_l),
        .crc_cbus_contr_cyc_l (crc_cbus_contr_cyc_l),
        .crc_wc_zero_h        (crc_wc_zero_h)
    );

    always #5 clk1_crc_h = ~clk1_crc_h;

    always @(posedge clk1_crc_h) if (crc_wr_ram_l === 1'b0) wr_cnt++;

    task automatic apply_reset;
        cbus_chan_req_h = '0;
        cbus_ready_e_h  = 1'b0;
        wc_load_h       = 1'b0;
        mr_reset_l      = 1'b1;
        #1 mr_reset_l   = 1'b0;
        repeat (2) @(negedge clk1_crc_h);
        mr_reset_l = 1'b1;
        @(negedge clk1_crc_h);
    endtask

    task automatic load_wc(input logic [2:0] ch, input logic [WC_W-1:0] v, input logic r);
        @(negedge clk1_crc_h);
        wc_load_h    = 1'b1;
        wc_load_chan = ch;
        wc_load_val  = v;
        wc_load_rev  = r;
        @(negedge clk1_crc_h);
        wc_load_h = 1'b0;
    endtask

    task automatic wait_slot(output int n);
        n = 0;
        while (!(crc_ready_in_h || crc_err_in_h) && n < 20) begin
            @(negedge clk1_crc_h);
            n++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if (crc_sel_c_h !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", crc_sel_c_h); end
        checks++;
        if (crc_ram_adr_r_l !== 3'b111) begin failures++; $display("FAIL reset_adr got=%b exp=111", crc_ram_adr_r_l); end
        checks++;
        if ({crc_ready_in_h, crc_last_word_in_h, crc_err_in_h, crc_reverse_in_h} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_h_outs got=%b exp=0000", {crc_ready_in_h, crc_last_word_in_h, crc_err_in_h, crc_reverse_in_h});
        end
        checks++;
        if ({crc_wr_ram_l, crc_cbus_contr_cyc_l} !== 2'b11) begin
            failures++;
            $display("FAIL reset_l_outs got=%b exp=11", {crc_wr_ram_l, crc_cbus_contr_cyc_l});
        end
        checks++;
        if (crc_wc_zero_h !== 8'hFF) begin failures++; $display("FAIL reset_wc_zero got=%h exp=ff", crc_wc_zero_h); end
    endtask

    task automatic test_words;
        int n, w0;
        load_wc(3'd3, 11'd2, 1'b1);
        w0 = wr_cnt;
        @(negedge clk1_crc_h);
        cbus_chan_req_h = 8'h08;
        wait_slot(n);
        checks++;
        if (n !== 2 || crc_ready_in_h !== 1'b1) begin failures++; $display("FAIL words_latency got=%0d exp=2", n); end
        checks++;
        if (crc_sel_c_h !== 3'd3) begin failures++; $display("FAIL words_sel got=%0d exp=3", crc_sel_c_h); end
        checks++;
        if (crc_ram_adr_r_l !== 3'b100) begin failures++; $display("FAIL words_adr got=%b exp=100", crc_ram_adr_r_l); end
        checks++;
        if (crc_reverse_in_h !== 1'b1) begin failures++; $display("FAIL words_rev got=%b exp=1", crc_reverse_in_h); end
        checks++;
        if (crc_last_word_in_h !== 1'b0) begin failures++; $display("FAIL words_last1 got=%b exp=0", crc_last_word_in_h); end
        cbus_ready_e_h = 1'b1;
        @(negedge clk1_crc_h);
        checks++;
        if (crc_wr_ram_l !== 1'b0) begin failures++; $display("FAIL words_wr_strobe got=%b exp=0", crc_wr_ram_l); end
        cbus_ready_e_h = 1'b0;
        wait_slot(n);
        checks++;
        if (n >= 20 || crc_last_word_in_h !== 1'b1) begin failures++; $display("FAIL words_last2 got=%b exp=1", crc_last_word_in_h); end
        cbus_ready_e_h = 1'b1;
        @(negedge clk1_crc_h);
        cbus_ready_e_h  = 1'b0;
        cbus_chan_req_h = '0;
        @(negedge clk1_crc_h);
        checks++;
        if (crc_wc_zero_h[3] !== 1'b1) begin failures++; $display("FAIL words_wc_zero got=%b exp=1", crc_wc_zero_h[3]); end
        checks++;
        if (wr_cnt - w0 !== 2) begin failures++; $display("FAIL words_wr_count got=%0d exp=2", wr_cnt - w0); end
    endtask

    task automatic test_round_robin;
        int n;
        chan_t exp_sel [6] = '{3'd0, 3'd5, 3'd7, 3'd0, 3'd5, 3'd7};
        apply_reset();
        load_wc(3'd0, 11'd4, 1'b0);
        load_wc(3'd5, 11'd4, 1'b0);
        load_wc(3'd7, 11'd4, 1'b0);
        cbus_chan_req_h = 8'hA1;
        for (int k = 0; k < 6; k++) begin
            wait_slot(n);
            checks++;
            if (n >= 20 || crc_sel_c_h !== exp_sel[k]) begin
                failures++;
                $display("FAIL rr_grant%0d got=%0d exp=%0d", k, crc_sel_c_h, exp_sel[k]);
            end
            cbus_ready_e_h = 1'b1;
            @(negedge clk1_crc_h);
            cbus_ready_e_h = 1'b0;
        end
        cbus_chan_req_h = '0;
        @(negedge clk1_crc_h);
    endtask

    task automatic test_overrun;
        int n, w0;
        load_wc(3'd2, 11'd0, 1'b0);
        w0 = wr_cnt;
        cbus_chan_req_h = 8'h04;
        wait_slot(n);
        checks++;
        if (n >= 20 || crc_err_in_h !== 1'b1 || crc_ready_in_h !== 1'b0) begin
            failures++;
            $display("FAIL ovr_grant got err=%b rdy=%b exp err=1 rdy=0", crc_err_in_h, crc_ready_in_h);
        end
        checks++;
        if (crc_sel_c_h !== 3'd2) begin failures++; $display("FAIL ovr_sel got=%0d exp=2", crc_sel_c_h); end
        @(negedge clk1_crc_h);
        checks++;
        if (crc_err_in_h !== 1'b1 || crc_cbus_contr_cyc_l !== 1'b0) begin
            failures++;
            $display("FAIL ovr_err_state got err=%b cyc_l=%b exp err=1 cyc_l=0", crc_err_in_h, crc_cbus_contr_cyc_l);
        end
        cbus_chan_req_h = '0;
        @(negedge clk1_crc_h);
        checks++;
        if (crc_err_in_h !== 1'b0 || crc_cbus_contr_cyc_l !== 1'b1) begin
            failures++;
            $display("FAIL ovr_idle got err=%b cyc_l=%b exp err=0 cyc_l=1", crc_err_in_h, crc_cbus_contr_cyc_l);
        end
        checks++;
        if (wr_cnt !== w0 || crc_wc_zero_h[2] !== 1'b1) begin
            failures++;
            $display("FAIL ovr_no_write got writes=%0d zero=%b exp writes=0 zero=1", wr_cnt - w0, crc_wc_zero_h[2]);
        end
    endtask

    task automatic test_timeout;
        int n, g;
        logic bad;
        load_wc(3'd1, 11'd5, 1'b0);
        cbus_chan_req_h = 8'h02;
        wait_slot(n);
        g = 1;
        while (!crc_err_in_h && g < 40) begin
            @(negedge clk1_crc_h);
            g++;
        end
        checks++;
        if (g !== 15) begin failures++; $display("FAIL tmo_cycles got=%0d exp=15", g); end
        @(negedge clk1_crc_h);
        checks++;
        if (crc_err_in_h !== 1'b1 || crc_ready_in_h !== 1'b0) begin
            failures++;
            $display("FAIL tmo_err_state got err=%b rdy=%b exp err=1 rdy=0", crc_err_in_h, crc_ready_in_h);
        end
        @(negedge clk1_crc_h);
        checks++;
        if (crc_cbus_contr_cyc_l !== 1'b1) begin failures++; $display("FAIL tmo_idle got cyc_l=%b exp=1", crc_cbus_contr_cyc_l); end
        wait_slot(n);
        repeat (14) @(negedge clk1_crc_h);
        cbus_ready_e_h = 1'b1;
        #1;
        checks++;
        if (crc_err_in_h !== 1'b0) begin failures++; $display("FAIL tmo_ack_wins got err=%b exp=0", crc_err_in_h); end
        @(negedge clk1_crc_h);
        checks++;
        if (crc_wr_ram_l !== 1'b0) begin failures++; $display("FAIL tmo_ack_update got wr_l=%b exp=0", crc_wr_ram_l); end
        cbus_ready_e_h = 1'b0;
        bad = 1'b0;
        for (int k = 1; k < 5; k++) begin
            wait_slot(n);
            if (n >= 20 || crc_err_in_h !== 1'b0 || crc_last_word_in_h !== (k == 4)) bad = 1'b1;
            cbus_ready_e_h = 1'b1;
            @(negedge clk1_crc_h);
            cbus_ready_e_h = 1'b0;
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL tmo_wc_kept got bad=%b exp=0", bad); end
        cbus_chan_req_h = '0;
        @(negedge clk1_crc_h);
    endtask

    task automatic test_load_collision;
        int n, k;
        logic done;
        load_wc(3'd4, 11'd3, 1'b0);
        cbus_chan_req_h = 8'h10;
        wait_slot(n);
        cbus_ready_e_h = 1'b1;
        @(negedge clk1_crc_h);
        checks++;
        if (crc_wr_ram_l !== 1'b0) begin failures++; $display("FAIL coll_update got wr_l=%b exp=0", crc_wr_ram_l); end
        cbus_ready_e_h = 1'b0;
        wc_load_h      = 1'b1;
        wc_load_chan   = 3'd4;
        wc_load_val    = 11'd9;
        wc_load_rev    = 1'b0;
        @(negedge clk1_crc_h);
        wc_load_h = 1'b0;
        k    = 0;
        done = 1'b0;
        while (!done && k < 20) begin
            wait_slot(n);
            k++;
            done = crc_last_word_in_h || n >= 20;
            cbus_ready_e_h = 1'b1;
            @(negedge clk1_crc_h);
            cbus_ready_e_h = 1'b0;
        end
        checks++;
        if (k !== 9) begin failures++; $display("FAIL coll_load_wins got words=%0d exp=9", k); end
        cbus_chan_req_h = '0;
        @(negedge clk1_crc_h);
        checks++;
        if (crc_wc_zero_h[4] !== 1'b1) begin failures++; $display("FAIL coll_wc_zero got=%b exp=1", crc_wc_zero_h[4]); end
    endtask

    task automatic test_mid_reset;
        int n, w0;
        load_wc(3'd6, 11'd3, 1'b1);
        w0 = wr_cnt;
        cbus_chan_req_h = 8'h40;
        wait_slot(n);
        checks++;
        if (n >= 20 || crc_ready_in_h !== 1'b1 || crc_sel_c_h !== 3'd6) begin
            failures++;
            $display("FAIL mid_grant got rdy=%b sel=%0d exp rdy=1 sel=6", crc_ready_in_h, crc_sel_c_h);
        end
        #2 mr_reset_l = 1'b0;
        #1;
        checks++;
        if ({crc_ready_in_h, crc_last_word_in_h, crc_err_in_h, crc_reverse_in_h} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_h_outs got=%b exp=0000", {crc_ready_in_h, crc_last_word_in_h, crc_err_in_h, crc_reverse_in_h});
        end
        checks++;
        if (crc_sel_c_h !== 3'd0 || crc_ram_adr_r_l !== 3'b111) begin
            failures++;
            $display("FAIL mid_sel_adr got sel=%0d adr=%b exp sel=0 adr=111", crc_sel_c_h, crc_ram_adr_r_l);
        end
        checks++;
        if ({crc_wr_ram_l, crc_cbus_contr_cyc_l} !== 2'b11 || crc_wc_zero_h !== 8'hFF) begin
            failures++;
            $display("FAIL mid_l_outs got=%b zero=%h exp=11 zero=ff", {crc_wr_ram_l, crc_cbus_contr_cyc_l}, crc_wc_zero_h);
        end
        @(negedge clk1_crc_h);
        mr_reset_l      = 1'b1;
        cbus_chan_req_h = 8'h41;
        wait_slot(n);
        checks++;
        if (n >= 20 || crc_sel_c_h !== 3'd0) begin failures++; $display("FAIL mid_ptr got sel=%0d exp=0", crc_sel_c_h); end
        cbus_chan_req_h = '0;
        repeat (2) @(negedge clk1_crc_h);
        checks++;
        if (wr_cnt !== w0) begin failures++; $display("FAIL mid_no_strobe got writes=%0d exp=0", wr_cnt - w0); end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_words();
        test_round_robin();
        test_overrun();
        test_timeout();
        test_load_collision();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
